seven_seg_scan_ctrl: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment display driver; successor to the fixed 8-digit out7/en_out path.

---
 rtl/seven_seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Purpose : N-digit multiplexed 7-segment scan driver with shadow-register updates,
//           leading-zero blanking and a per-digit enable mask.
// Latency : out7/en_out are registered; they follow the scan index by one Clk.
//           A load becomes visible at the next frame start.
// Backpr. : none; load is a fire-and-forget strobe, and the last load before a frame start wins.
// Option  : define SEVSEG_BLINK_EN to add the blink_mask input and the BLINK_FRAMES frame counter.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int PRESCALE       = 100000,
    parameter bit ACTIVE_LOW_OUT = 1'b1
`ifdef SEVSEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 64
`endif
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     digit_mask,
`ifdef SEVSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink_mask,
`endif
    output logic                      pending,
    output logic                      frame_tick,
    output logic [6:0]                out7,
    output logic [NUM_DIGITS-1:0]     en_out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (PRESCALE > 1)   ? $clog2(PRESCALE)   : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]       LAST_PS  = PS_W'(PRESCALE - 1);

    // "Off" levels for the pins, depending on board polarity
    localparam logic [6:0]            SEG_OFF  = ACTIVE_LOW_OUT ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] EN_OFF   = ACTIVE_LOW_OUT ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};
    localparam logic                  EN_ON_BIT = ~ACTIVE_LOW_OUT;

    // Active-high hex decode, bit order {g,f,e,d,c,b,a}; b and d are lowercase,
    // and 6 and 9 are drawn with their tails.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // State
    logic [PS_W-1:0]          prescale_q, prescale_d;
    logic [IDX_W-1:0]         index_q,    index_d;
    logic [4*NUM_DIGITS-1:0]  shadow_q,   shadow_d;
    logic [4*NUM_DIGITS-1:0]  display_q,  display_d;
    logic                     pending_q,  pending_d;
    logic                     frame_tick_q, frame_tick_d;
    logic [6:0]               seg_q,      seg_d;
    logic [NUM_DIGITS-1:0]    en_q,       en_d;

    // Combinational helpers
    logic                     slot_tick;
    logic                     frame_start;
    logic                     lz_run;
    logic [NUM_DIGITS-1:0]    lz_dark;
    logic [NUM_DIGITS-1:0]    blink_dark;
    logic [NUM_DIGITS-1:0]    digit_dark;
    logic [3:0]               cur_nib;
    logic                     cur_dark;

    // Prescaler and scan index: one slot per PRESCALE cycles, wrap to digit 0 marks a frame
    always_comb begin
        slot_tick   = (prescale_q == LAST_PS);
        prescale_d  = slot_tick ? '0 : prescale_q + PS_W'(1);
        index_d     = index_q;
        if (slot_tick) begin
            index_d = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
        end
        frame_start = slot_tick && (index_q == LAST_IDX);
    end

    // Shadow/display handoff: a load always lands in the shadow; the display only
    // takes the shadow at a frame start, so a digit never changes mid-frame.
    always_comb begin
        shadow_d     = load ? value_in : shadow_q;
        display_d    = display_q;
        pending_d    = pending_q;
        frame_tick_d = frame_start;
        if (frame_start && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
        // A load coinciding with the transfer leaves fresh data waiting
        if (load) begin
            pending_d = 1'b1;
        end
    end

    // Leading-zero blanking: walk from the most significant digit down while every nibble is zero
    always_comb begin
        lz_run  = 1'b1;
        lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run && (display_q[4*i +: 4] == 4'h0);
            lz_dark[i] = blank_lz && lz_run && (i != 0);
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int BF_W = $clog2(2 * BLINK_FRAMES);
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(2 * BLINK_FRAMES - 1);
    localparam logic [BF_W-1:0] BF_HALF = BF_W'(BLINK_FRAMES);

    logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;

    // Frame counter over one full blink period; the upper half is the dark phase
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (frame_start) begin
            blink_cnt_d = (blink_cnt_q == BF_LAST) ? '0 : blink_cnt_q + BF_W'(1);
        end
        blink_dark = (blink_cnt_q >= BF_HALF) ? blink_mask : '0;
    end

    // Blink frame counter register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end
`else
    // Without the blink option no digit is ever blink-darkened
    always_comb begin
        blink_dark = '0;
    end
`endif

    // Per-digit darkness: mask, then leading-zero blanking, then blink
    always_comb begin
        digit_dark = ~digit_mask | lz_dark | blink_dark;
    end

    // Output decode for the current slot; at most one enable bit is ever driven on
    always_comb begin
        cur_nib  = 4'h0;
        cur_dark = 1'b1;
        en_d     = EN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_q == IDX_W'(i)) begin
                cur_nib  = display_q[4*i +: 4];
                cur_dark = digit_dark[i];
                if (!digit_dark[i]) begin
                    en_d[i] = EN_ON_BIT;
                end
            end
        end
        if (cur_dark) begin
            seg_d = SEG_OFF;
        end else if (ACTIVE_LOW_OUT) begin
            seg_d = ~hex7(cur_nib);
        end else begin
            seg_d = hex7(cur_nib);
        end
    end

    // State registers; reset restarts the scan at digit 0 and drops any queued value
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prescale_q   <= '0;
            index_q      <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_OFF;
            en_q         <= EN_OFF;
        end else begin
            prescale_q   <= prescale_d;
            index_q      <= index_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            en_q         <= en_d;
        end
    end

    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;
    assign out7       = seg_q;
    assign en_out     = en_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with 4 digits, prescale 4, active-low pins.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_seven_seg_scan_ctrl;

    logic        Clk;
    logic        Reset;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  digit_mask;
    logic        pending;
    logic        frame_tick;
    logic [6:0]  out7;
    logic [3:0]  en_out;
`ifdef SEVSEG_BLINK_EN
    logic [3:0]  blink_mask;
`endif

    int checks = 0;
    int errors = 0;

    // Active-low segment patterns used below
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS     (4),
        .PRESCALE       (4),
        .ACTIVE_LOW_OUT (1'b1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .value_in   (value_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .digit_mask (digit_mask),
`ifdef SEVSEG_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .pending    (pending),
        .frame_tick (frame_tick),
        .out7       (out7),
        .en_out     (en_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Wait (bounded) for the next frame_tick pulse, sampled on falling edges
    task automatic wait_ft(input string tag);
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk(tag, {15'd0, frame_tick}, 16'd1);
    endtask

    task automatic load_val(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
    endtask

    initial begin
        Reset      = 1'b1;
        value_in   = 16'h0000;
        load       = 1'b0;
        blank_lz   = 1'b0;
        digit_mask = 4'hF;
`ifdef SEVSEG_BLINK_EN
        blink_mask = 4'h0;
`endif
        #2 Reset = 1'b0;
        step(3);

        // Reset state
        chk("rst_out7",    {9'd0, out7},        {9'd0, SEG_OFF});
        chk("rst_en",      {12'd0, en_out},     16'h000F);
        chk("rst_pending", {15'd0, pending},    16'd0);
        chk("rst_ftick",   {15'd0, frame_tick}, 16'd0);

        // Release: first slot is digit 0 showing '0'; scan rotates every 4 cycles
        Reset = 1'b1;
        step(1);
        chk("rel_en0",   {12'd0, en_out}, 16'h000E);
        chk("rel_out0",  {9'd0, out7},    {9'd0, SEG_0});
        step(4);
        chk("rot_en1",   {12'd0, en_out}, 16'h000D);
        step(4);
        chk("rot_en2",   {12'd0, en_out}, 16'h000B);
        step(4);
        chk("rot_en3",   {12'd0, en_out}, 16'h0007);
        step(2);
        chk("ft_before", {15'd0, frame_tick}, 16'd0);
        step(1);
        chk("ft_at16",   {15'd0, frame_tick}, 16'd1);
        chk("ft_en3",    {12'd0, en_out},     16'h0007);
        step(1);
        chk("ft_after",  {15'd0, frame_tick}, 16'd0);
        chk("wrap_en0",  {12'd0, en_out},     16'h000E);

        // Load 1234, then wiggle value_in without load: must be ignored
        load_val(16'h1234);
        chk("ld_pending", {15'd0, pending}, 16'd1);
        value_in = 16'hFFFF;
        step(3);
        chk("ld_pend_hold", {15'd0, pending}, 16'd1);
        wait_ft("ld_ft");
        chk("ld_pend_clr", {15'd0, pending}, 16'd0);
        step(1);
        chk("d0_en",  {12'd0, en_out}, 16'h000E);
        chk("d0_seg", {9'd0, out7},    {9'd0, SEG_4});
        step(4);
        chk("d1_en",  {12'd0, en_out}, 16'h000D);
        chk("d1_seg", {9'd0, out7},    {9'd0, SEG_3});
        step(4);
        chk("d2_seg", {9'd0, out7},    {9'd0, SEG_2});
        step(4);
        chk("d3_seg", {9'd0, out7},    {9'd0, SEG_1});

        // Two loads in one frame: last one wins
        load_val(16'hAAAA);
        load_val(16'h5555);
        chk("ll_pending", {15'd0, pending}, 16'd1);
        wait_ft("ll_ft");
        chk("ll_pend_clr", {15'd0, pending}, 16'd0);
        step(1);
        chk("ll_d0", {9'd0, out7}, {9'd0, SEG_5});
        step(4);
        chk("ll_d1", {9'd0, out7}, {9'd0, SEG_5});

        // Leading-zero blanking of 0042
        blank_lz = 1'b1;
        load_val(16'h0042);
        wait_ft("lz_ft");
        step(1);
        chk("lz_d0_en",  {12'd0, en_out}, 16'h000E);
        chk("lz_d0_seg", {9'd0, out7},    {9'd0, SEG_2});
        step(4);
        chk("lz_d1_en",  {12'd0, en_out}, 16'h000D);
        chk("lz_d1_seg", {9'd0, out7},    {9'd0, SEG_4});
        step(4);
        chk("lz_d2_en",  {12'd0, en_out}, 16'h000F);
        chk("lz_d2_seg", {9'd0, out7},    {9'd0, SEG_OFF});
        step(4);
        chk("lz_d3_en",  {12'd0, en_out}, 16'h000F);

        // All-zero value: only digit 0 stays lit
        load_val(16'h0000);
        wait_ft("z_ft");
        step(1);
        chk("z_d0_en",  {12'd0, en_out}, 16'h000E);
        chk("z_d0_seg", {9'd0, out7},    {9'd0, SEG_0});
        step(4);
        chk("z_d1_en",  {12'd0, en_out}, 16'h000F);
        chk("z_d1_seg", {9'd0, out7},    {9'd0, SEG_OFF});

        // Digit mask darkens digit 2 even without blanking
        blank_lz   = 1'b0;
        digit_mask = 4'b1011;
        step(4);
        chk("mk_d2_en",  {12'd0, en_out}, 16'h000F);
        chk("mk_d2_seg", {9'd0, out7},    {9'd0, SEG_OFF});
        step(4);
        chk("mk_d3_en",  {12'd0, en_out}, 16'h0007);
        chk("mk_d3_seg", {9'd0, out7},    {9'd0, SEG_0});
        digit_mask = 4'hF;

        // Reset mid-frame with a pending load: outputs go off at once, shadow discarded
        load_val(16'h9999);
        chk("mr_pending", {15'd0, pending}, 16'd1);
        Reset = 1'b0;
        #1;
        chk("mr_out7",    {9'd0, out7},     {9'd0, SEG_OFF});
        chk("mr_en",      {12'd0, en_out},  16'h000F);
        chk("mr_pending0",{15'd0, pending}, 16'd0);
        step(2);
        Reset = 1'b1;
        step(1);
        chk("mr_rel_en",  {12'd0, en_out}, 16'h000E);
        chk("mr_rel_seg", {9'd0, out7},    {9'd0, SEG_0});
        wait_ft("mr_ft");
        chk("mr_pend_ft", {15'd0, pending}, 16'd0);
        step(1);
        chk("mr_nf_seg",  {9'd0, out7},    {9'd0, SEG_0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
